// File: rtl/fixed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fixed_pkg                                                 |
// | Desc     : Shared constants, types and state encoding for the Q16.16 |
// |            sign-magnitude fixed-point library.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fixed_pkg;

  localparam int N = 32;   // word width, bit N-1 is the sign
  localparam int Q = 16;   // fraction bits and number of log2 iterations

  typedef logic [N-1:0] fixed_t;

  localparam fixed_t LN2        = 32'h0000B172;  // ln(2) in Q16.16
  localparam fixed_t ONE        = 32'h00010000;  // 1.0 in Q16.16
  localparam fixed_t ERR_RESULT = 32'hFFFFFFFF;  // returned for x <= 0

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_ITER  = 3'd2,
    ST_SCALE = 3'd3,
    ST_DONE  = 3'd4
  } ln_state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_msb_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fixed_msb_enc                                             |
// | Desc     : 31-bit priority encoder: index of the highest set bit and |
// |            an all-zero flag. Shared by log/reciprocal/exp seeding.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fixed_msb_enc (
  input  logic [30:0] i_mag,
  output logic [4:0]  o_p,
  output logic        o_zero
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    o_p = 5'd0;
    for (int i = 0; i < 31; i++) begin
      if (i_mag[i]) begin
        o_p = 5'(i);
      end
    end
    o_zero = (i_mag == 31'd0);
  end

endmodule
`default_nettype wire

// File: rtl/fixed_ln.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fixed_ln                                                  |
// | Desc     : Sequential natural log, Q16.16 sign-magnitude. Normalises |
// |            x = 2^k * m, extracts one log2 fraction bit per cycle by  |
// |            squaring m, then scales (k + frac) by ln2.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fixed_ln
  import fixed_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err
);

  ln_state_t         state_q, state_d;
  fixed_t            x_q, x_d;
  logic [31:0]       m_q, m_d;        // mantissa, unsigned Q2.30 in [1,2)
  logic [Q-1:0]      frac_q, frac_d;  // log2 fraction bits, MSB first
  logic [3:0]        cnt_q, cnt_d;
  logic signed [5:0] k_q, k_d;        // exponent, -16..14
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  fixed_t            result_q, result_d;

  logic [4:0]  w_p;
  logic        w_zero;
  logic [63:0] w_sq;
  logic [23:0] w_l;
  logic [23:0] w_l_abs;
  logic [47:0] w_prod;
  logic [30:0] w_mag;
  logic        w_neg;
  logic        w_unused;

  fixed_msb_enc u_msb_enc (
    .i_mag  (x_q[30:0]),
    .o_p    (w_p),
    .o_zero (w_zero)
  );

  // m*m lands in Q4.60, value in [1,4).
  assign w_sq = {32'd0, m_q} * {32'd0, m_q};

  // L = k*2^16 + frac: sign-extended k above the non-negative fraction.
  assign w_l     = {{2{k_q[5]}}, k_q, frac_q};
  assign w_l_abs = w_l[23] ? (~w_l + 24'd1) : w_l;
  assign w_prod  = {24'd0, w_l_abs} * {16'd0, LN2};
  assign w_mag   = w_prod[46:16];
  assign w_neg   = w_l[23] & (w_mag != 31'd0);

  // Truncated product bits that are never needed.
  assign w_unused = ^{w_sq[63], w_sq[29:0], w_prod[47], w_prod[15:0]};

  // Next-state and datapath update for the log sequencer.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    m_d      = m_q;
    frac_d   = frac_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          busy_d  = 1'b1;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (w_zero || x_q[31]) begin
          state_d = ST_DONE;
        end else begin
          k_d     = $signed({1'b0, w_p}) - 6'sd16;
          m_d     = {1'b0, x_q[30:0]} << (5'd30 - w_p);
          frac_d  = '0;
          cnt_d   = 4'd0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        // Squaring doubles log2(m); an overflow past 2 yields a 1 bit
        // and the square is halved back into [1,2).
        if (w_sq[61]) begin
          frac_d = {frac_q[Q-2:0], 1'b1};
          m_d    = w_sq[62:31];
        end else begin
          frac_d = {frac_q[Q-2:0], 1'b0};
          m_d    = w_sq[61:30];
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(Q-1)) begin
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        // Completion is signalled here so done lands Q+2 edges after
        // acceptance and the sequencer is already idle for back-to-back use.
        result_d = {w_neg, w_mag};
        err_d    = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_DONE: begin
        // Only the invalid-operand path arrives here; the error result is
        // published together with done so the previous result holds until now.
        result_d = ERR_RESULT;
        err_d    = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      m_q      <= '0;
      frac_q   <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      m_q      <= m_d;
      frac_q   <= frac_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
`default_nettype wire
